instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 21 ++
 rtl/instruction_fetch.sv | 88 ++++++++
 tb/tb_instruction_fetch.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction-memory handshake, decode-side queue head and redirect signals
interface instruction_fetch_if #(parameter int PC_WIDTH = 32);
  logic                imemReq;
  logic [PC_WIDTH-1:0] imemAddr;
  logic                imemAck;
  logic [31:0]         imemData;
  logic [31:0]         instruction;
  logic [PC_WIDTH-1:0] instructionPC;
  logic                instructionValid;
  logic                decodeReady;
  logic                redirectValid;
  logic [PC_WIDTH-1:0] redirectTarget;
  modport master (
    output imemReq, imemAddr, instruction, instructionPC, instructionValid,
    input  imemAck, imemData, decodeReady, redirectValid, redirectTarget
  );
  modport slave (
    input  imemReq, imemAddr, instruction, instructionPC, instructionValid,
    output imemAck, imemData, decodeReady, redirectValid, redirectTarget
  );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, req/ack fetch FSM and small instruction FIFO feeding decode
module instruction_fetch #(
  parameter int                  PC_WIDTH    = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
  parameter int                  QUEUE_DEPTH = 2
) (
  input logic                  clock,
  input logic                  resetN,
  instruction_fetch_if.master  bus
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(QUEUE_DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;
  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt, r_addr, w_addr_nxt, w_pc_inc, w_target;
  logic                r_req, w_req_nxt;
  logic [31:0]         r_data [QUEUE_DEPTH];
  logic [PC_WIDTH-1:0] r_ipc  [QUEUE_DEPTH];
  logic [AW-1:0]       r_wr, r_rd;
  logic [AW:0]         r_count, w_count_nxt;
  logic                w_push, w_pop, w_redir, w_valid;
  assign w_redir     = bus.redirectValid;
  assign w_target    = bus.redirectTarget & ~PC_WIDTH'(3);
  assign w_pc_inc    = r_pc + PC_WIDTH'(4);
  assign w_valid     = r_count != '0;
  assign w_push      = r_state == WAIT && bus.imemAck && !w_redir;
  assign w_pop       = w_valid && bus.decodeReady && !w_redir;
  assign w_count_nxt = w_redir ? '0 : r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign bus.imemReq          = r_req;
  assign bus.imemAddr         = r_addr;
  assign bus.instructionValid = w_valid;
  assign bus.instruction      = w_valid ? r_data[r_rd] : '0;
  assign bus.instructionPC    = w_valid ? r_ipc[r_rd] : '0;
  // a request already presented cannot be withdrawn, so a redirect without ack waits it out in DISCARD
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_pc_nxt    = r_pc;
    if (w_redir) begin
      w_pc_nxt = w_target;
      if (r_state == IDLE || bus.imemAck) begin
        w_state_nxt = IDLE;
        w_req_nxt   = 1'b0;
      end else w_state_nxt = DISCARD;
    end else if (r_state == IDLE) begin
      if (r_count < DEPTH) begin
        w_state_nxt = WAIT;
        w_req_nxt   = 1'b1;
        w_addr_nxt  = r_pc;
      end
    end else if (bus.imemAck) begin
      w_req_nxt   = r_state == WAIT && w_count_nxt < DEPTH;
      w_state_nxt = w_req_nxt ? WAIT : IDLE;
      if (r_state == WAIT) begin
        w_pc_nxt   = w_pc_inc;
        w_addr_nxt = w_pc_inc;
      end
    end
  end
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
      r_req   <= 1'b0;
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
      r_req   <= w_req_nxt;
      r_wr    <= w_redir ? '0 : r_wr + AW'(w_push);
      r_rd    <= w_redir ? '0 : r_rd + AW'(w_pop);
      r_count <= w_count_nxt;
    end
  end
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_data[r_wr] <= bus.imemData;
      r_ipc[r_wr]  <= r_addr;
    end
  end
  a_no_overflow: assert property (@(posedge clock) disable iff (!resetN)
    !(w_push && !w_pop && r_count == DEPTH));
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: vector table, hand sequences and randomized run against a queue-based fetch model
module tb_instruction_fetch;
  logic clock = 1'b0;
  logic resetN = 1'b0;
  logic resetN_w = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clock = ~clock;
  instruction_fetch_if #(.PC_WIDTH(32)) bus ();
  instruction_fetch_if #(.PC_WIDTH(32)) bus_w ();
  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'h0), .QUEUE_DEPTH(2)) dut (
    .clock(clock), .resetN(resetN), .bus(bus));
  instruction_fetch #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .QUEUE_DEPTH(2)) dut_w (
    .clock(clock), .resetN(resetN_w), .bus(bus_w));
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction
  assign bus.imemData         = mem(bus.imemAddr);
  assign bus_w.imemData       = mem(bus_w.imemAddr);
  assign bus_w.imemAck        = bus_w.imemReq;
  assign bus_w.decodeReady    = 1'b1;
  assign bus_w.redirectValid  = 1'b0;
  assign bus_w.redirectTarget = 32'h0;
  typedef struct {
    logic ack, rdy, redir;
    logic [31:0] tgt;
    logic req;
    logic [31:0] addr;
    logic vld;
    logic [31:0] ipc;
  } vec_t;
  vec_t tbl [17];
  logic [63:0] q [$];
  logic [31:0] m_pc, m_addr;
  logic m_req, m_disc;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, a, e);
    end
  endtask
  task automatic chk_out(input string t, input logic req, input logic [31:0] addr, input logic vld, input logic [31:0] ipc);
    chk({t, " imemReq"}, 32'(bus.imemReq), 32'(req));
    chk({t, " imemAddr"}, bus.imemAddr, addr);
    chk({t, " instructionValid"}, 32'(bus.instructionValid), 32'(vld));
    chk({t, " instructionPC"}, bus.instructionPC, vld ? ipc : 32'h0);
    chk({t, " instruction"}, bus.instruction, vld ? mem(ipc) : 32'h0);
  endtask
  task automatic drive(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    bus.imemAck        = ack;
    bus.decodeReady    = rdy;
    bus.redirectValid  = redir;
    bus.redirectTarget = tgt;
  endtask
  // one clock edge of fetch behaviour: flush on redirect, else pop, then ack completion or a new issue
  task automatic model_step(input logic ack, input logic rdy, input logic redir, input logic [31:0] tgt);
    int n = q.size();
    if (redir) begin
      q.delete();
      m_pc = tgt & ~32'h3;
      if (m_req && !ack) m_disc = 1'b1;
      else begin
        m_req  = 1'b0;
        m_disc = 1'b0;
      end
    end else begin
      if (n > 0 && rdy) void'(q.pop_front());
      if (m_req && ack) begin
        if (m_disc) begin
          m_req  = 1'b0;
          m_disc = 1'b0;
        end else begin
          q.push_back({mem(m_addr), m_addr});
          m_pc   = m_pc + 32'd4;
          m_addr = m_pc;
          m_req  = q.size() < 2;
        end
      end else if (!m_req && n < 2) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end
  endtask
  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h4};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h8};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'h8};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h10,  1'b1, 32'hC};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'hC};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h42,  1'b1, 32'h10,  1'b1, 32'hC};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h10,  1'b0, 32'h0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 32'h102, 1'b1, 32'h44,  1'b1, 32'h40};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h44,  1'b0, 32'h0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 17; i++) begin
      chk_out($sformatf("vec%0d", i), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ipc);
      drive(tbl[i].ack, tbl[i].rdy, tbl[i].redir, tbl[i].tgt);
      @(negedge clock);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    q.delete();
    m_pc = 32'h0; m_addr = 32'h0; m_req = 1'b0; m_disc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic a, r, d;
      logic [31:0] t;
      chk_out("rand", m_req, m_addr, q.size() > 0, q.size() > 0 ? q[0][31:0] : 32'h0);
      a = m_req && ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 3) != 0;
      d = $urandom_range(0, 15) == 0;
      t = $urandom;
      drive(a, r, d, t);
      @(posedge clock);
      model_step(a, r, d, t);
      @(negedge clock);
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    resetN = 1'b0;
    @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    chk_out("pre_rst", 1'b1, 32'h4, 1'b1, 32'h0);
    #2 resetN = 1'b0;
    #1 chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clock);
    resetN = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 32'h0);
    @(posedge clock);
    #1 chk_out("stray_ack", 1'b1, 32'h0, 1'b0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    resetN_w = 1'b1;
    @(negedge clock);
    chk("wrap addr0", bus_w.imemAddr, 32'hFFFF_FFF8);
    @(negedge clock);
    chk("wrap addr1", bus_w.imemAddr, 32'hFFFF_FFFC);
    chk("wrap ipc0", bus_w.instructionPC, 32'hFFFF_FFF8);
    @(negedge clock);
    chk("wrap addr2", bus_w.imemAddr, 32'h0);
    chk("wrap ipc1", bus_w.instructionPC, 32'hFFFF_FFFC);
    chk("wrap req", 32'(bus_w.imemReq), 32'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
